// File: rtl/axil_debug_master.sv
// Byte-stream command front end that issues single AXI4-Lite reads/writes for a host debug/loader link.
// 'W' A0..A3 D0..D3 -> write, reply 'K'/'E'; 'R' A0..A3 -> read, reply 'K' R0..R3 or 'E'.
module axil_debug_master #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WREQ, WRESP, RREQ, RRESP, SEND} state_t;

  state_t        state_r;
  logic          is_write_r;
  logic          resp_err_r;
  logic [2:0]    cnt_r;
  logic [31:0]   addr_r;
  logic [31:0]   data_r;
  logic [TW-1:0] tmo_r;
  logic          rx_ready_r;
  logic [7:0]    tx_data_r;
  logic          tx_valid_r;
  logic          awvalid_r;
  logic          wvalid_r;
  logic          bready_r;
  logic          arvalid_r;
  logic          rready_r;

  logic rx_hs_s;
  logic aw_done_s;
  logic w_done_s;
  logic tmo_hit_s;
  logic tx_last_s;

  assign rx_hs_s   = rx_valid && rx_ready_r;
  assign aw_done_s = !awvalid_r || awready;
  assign w_done_s  = !wvalid_r || wready;
  assign tmo_hit_s = (tmo_r == TW'(TIMEOUT_CYCLES - 1));
  // Only a successful read reply carries data bytes; the byte counter reaches 4 on R3.
  assign tx_last_s = is_write_r || resp_err_r || (cnt_r == 3'd4);

  assign rx_ready = rx_ready_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign awaddr   = addr_r;
  assign awprot   = 3'b000;
  assign awvalid  = awvalid_r;
  assign wdata    = data_r;
  assign wstrb    = 4'hF;
  assign wvalid   = wvalid_r;
  assign bready   = bready_r;
  assign araddr   = addr_r;
  assign arprot   = 3'b000;
  assign arvalid  = arvalid_r;
  assign rready   = rready_r;

  // Command parser, AXI-Lite sequencer and reply serialiser.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      is_write_r <= 1'b0;
      resp_err_r <= 1'b0;
      cnt_r      <= 3'd0;
      addr_r     <= 32'h0000_0000;
      data_r     <= 32'h0000_0000;
      tmo_r      <= '0;
      rx_ready_r <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rx_ready_r <= 1'b1;
          tmo_r      <= '0;
          cnt_r      <= 3'd0;
          if (rx_hs_s && (rx_data == CMD_W || rx_data == CMD_R)) begin
            is_write_r <= (rx_data == CMD_W);
            state_r    <= ADDR;
          end
        end
        ADDR, DATA: begin
          if (rx_hs_s) begin
            tmo_r <= '0;
            cnt_r <= cnt_r + 3'd1;
            if (state_r == ADDR) begin
              addr_r[{cnt_r[1:0], 3'b000} +: 8] <= rx_data;
            end else begin
              data_r[{cnt_r[1:0], 3'b000} +: 8] <= rx_data;
            end
            if (cnt_r == 3'd3) begin
              cnt_r <= 3'd0;
              if (state_r == ADDR && is_write_r) begin
                state_r <= DATA;
              end else begin
                rx_ready_r <= 1'b0;
                if (is_write_r) begin
                  state_r   <= WREQ;
                  awvalid_r <= 1'b1;
                  wvalid_r  <= 1'b1;
                end else begin
                  state_r   <= RREQ;
                  arvalid_r <= 1'b1;
                end
              end
            end
          end else if (tmo_hit_s) begin
            // Stalled partial command: drop it silently and resynchronise on the next byte.
            state_r <= IDLE;
            tmo_r   <= '0;
            cnt_r   <= 3'd0;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        WREQ: begin
          if (awvalid_r && awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            state_r  <= WRESP;
            bready_r <= 1'b1;
          end
        end
        WRESP: begin
          if (bvalid) begin
            bready_r   <= 1'b0;
            resp_err_r <= (bresp != 2'b00);
            tx_data_r  <= (bresp == 2'b00) ? RSP_K : RSP_E;
            tx_valid_r <= 1'b1;
            cnt_r      <= 3'd0;
            state_r    <= SEND;
          end
        end
        RREQ: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RRESP;
          end
        end
        RRESP: begin
          if (rvalid) begin
            rready_r   <= 1'b0;
            data_r     <= rdata;
            resp_err_r <= (rresp != 2'b00);
            tx_data_r  <= (rresp == 2'b00) ? RSP_K : RSP_E;
            tx_valid_r <= 1'b1;
            cnt_r      <= 3'd0;
            state_r    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (tx_last_s) begin
              tx_valid_r <= 1'b0;
              rx_ready_r <= 1'b1;
              cnt_r      <= 3'd0;
              state_r    <= IDLE;
            end else begin
              tx_data_r <= data_r[{cnt_r[1:0], 3'b000} +: 8];
              cnt_r     <= cnt_r + 3'd1;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          rx_ready_r <= 1'b0;
          tx_valid_r <= 1'b0;
          awvalid_r  <= 1'b0;
          wvalid_r   <= 1'b0;
          bready_r   <= 1'b0;
          arvalid_r  <= 1'b0;
          rready_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_debug_master.sv
// Directed bench for axil_debug_master: byte-stream host on rx/tx, configurable AXI-Lite slave model.
module tb_axil_debug_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;

  int n_tests = 0;
  int n_fail = 0;

  // slave model state and configuration
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int          aw_age = 0, w_age = 0;
  int          aw_dly = 0, w_dly = 0;
  logic        b_stall = 1'b0, tx_toggle = 1'b0;
  logic        b_pending = 1'b0, r_pending = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  logic [31:0] cap_awaddr = 32'h0, cap_wdata = 32'h0, cap_araddr = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;
  logic [2:0]  cap_awprot = 3'h7, cap_arprot = 3'h7;
  logic [7:0]  tx_q[$];

  axil_debug_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave and transmitter model: drives at negedge; a handshake seen here completes at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        b_pending = 1'b0; r_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        aw_age = 0; w_age = 0;
        tx_ready = 1'b0;
      end else begin
        bvalid = b_pending && !b_stall;
        bresp  = cfg_bresp;
        rvalid = r_pending;
        rdata  = cfg_rdata;
        rresp  = cfg_rresp;
        if (awvalid) begin awready = (aw_age >= aw_dly); aw_age++; end
        else begin awready = 1'b0; aw_age = 0; end
        if (wvalid) begin wready = (w_age >= w_dly); w_age++; end
        else begin wready = 1'b0; w_age = 0; end
        arready = arvalid;
        if (awvalid && awready) begin
          aw_hs++; aw_got = 1'b1; cap_awaddr = awaddr; cap_awprot = awprot;
        end
        if (wvalid && wready) begin
          w_hs++; w_got = 1'b1; cap_wdata = wdata; cap_wstrb = wstrb;
        end
        if (aw_got && w_got) begin b_pending = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
        if (bvalid && bready) begin b_hs++; b_pending = 1'b0; end
        if (arvalid && arready) begin
          ar_hs++; r_pending = 1'b1; cap_araddr = araddr; cap_arprot = arprot;
        end
        if (rvalid && rready) begin r_hs++; r_pending = 1'b0; end
        tx_ready = tx_toggle ? ~tx_ready : 1'b1;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", rx_ready, 1'b1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    chk("w_req_latency", {awvalid, wvalid, rx_ready}, 3'b110);
  endtask

  task automatic do_read(input logic [31:0] a, input int gap);
    send_byte(8'h52);
    send_byte(a[7:0]);
    repeat (gap) @(posedge clk);
    for (int i = 1; i < 4; i++) send_byte(a[8*i +: 8]);
    chk("r_req_latency", {arvalid, rx_ready}, 2'b10);
  endtask

  // exp holds the reply bytes in transmit order, first byte most significant.
  task automatic expect_tx(input string tag, input logic [39:0] exp, input int n);
    int k;
    logic [7:0] b;
    k = 0;
    while (tx_q.size() < n && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (12) @(posedge clk);
    #1;
    chk({tag, "_len"}, tx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      b = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      chk({tag, "_byte"}, b, exp[8*(n-1-i) +: 8]);
    end
    tx_q.delete();
  endtask

  int aw0, w0, b0, ar0;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valids", {rx_ready, tx_valid, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
    chk("reset_regs", {awaddr, wdata}, 64'h0);
    chk("reset_araddr_tx", {araddr, tx_data}, 40'h0);
    @(negedge clk);
    rst = 1'b0;

    // T1: basic write
    aw0 = aw_hs; w0 = w_hs;
    do_write(32'h2000_0000, 32'hDEAD_BEEF);
    expect_tx("t1_reply", 40'h4B, 1);
    chk("t1_aw_count", aw_hs - aw0, 1);
    chk("t1_w_count", w_hs - w0, 1);
    chk("t1_awaddr", cap_awaddr, 32'h2000_0000);
    chk("t1_wdata", cap_wdata, 32'hDEAD_BEEF);
    chk("t1_wstrb_prot", {cap_wstrb, cap_awprot}, 7'b1111_000);

    // T2: basic read
    ar0 = ar_hs;
    cfg_rdata = 32'h1234_5678;
    do_read(32'h0000_0004, 0);
    expect_tx("t2_reply", 40'h4B78563412, 5);
    chk("t2_araddr", cap_araddr, 32'h0000_0004);
    chk("t2_arprot", cap_arprot, 3'b000);
    chk("t2_ar_count", ar_hs - ar0, 1);

    // T3: error responses
    cfg_bresp = 2'b10;
    do_write(32'h0000_0100, 32'h5555_AAAA);
    expect_tx("t3_write_err", 40'h45, 1);
    cfg_bresp = 2'b00;
    cfg_rresp = 2'b11;
    do_read(32'h0000_0008, 0);
    expect_tx("t3_read_err", 40'h45, 1);
    cfg_rresp = 2'b00;

    // T4: unknown opcode is discarded
    ar0 = ar_hs; aw0 = aw_hs;
    send_byte(8'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_traffic", {ar_hs - ar0, aw_hs - aw0}, 64'h0);
    chk("t4_rx_ready", rx_ready, 1'b1);
    cfg_rdata = 32'hCAFE_F00D;
    do_read(32'h0000_0010, 0);
    expect_tx("t4_reply", 40'h4B0DF0FECA, 5);
    chk("t4_araddr", cap_araddr, 32'h0000_0010);

    // T5: a 12-cycle pause stays below the timeout
    cfg_rdata = 32'h0000_0042;
    do_read(32'h0403_0201, 12);
    expect_tx("t5_slow_reply", 40'h4B42000000, 5);
    chk("t5_slow_araddr", cap_araddr, 32'h0403_0201);

    // T5: partial write abandoned for 20 cycles times out
    aw0 = aw_hs; ar0 = ar_hs;
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_traffic", {aw_hs - aw0, ar_hs - ar0}, 64'h0);
    chk("t5_no_tx", tx_q.size(), 0);
    cfg_rdata = 32'h0BAD_BEEF;
    do_read(32'h0000_0030, 0);
    expect_tx("t5_reply", 40'h4BEFBEAD0B, 5);
    chk("t5_araddr", cap_araddr, 32'h0000_0030);
    chk("t5_ar_count", ar_hs - ar0, 1);

    // T6: skewed AW/W readies and a toggling transmitter
    aw_dly = 0; w_dly = 3; tx_toggle = 1'b1;
    aw0 = aw_hs; w0 = w_hs;
    do_write(32'h0000_0044, 32'h0102_0304);
    expect_tx("t6_write_reply", 40'h4B, 1);
    chk("t6_aw_count", aw_hs - aw0, 1);
    chk("t6_w_count", w_hs - w0, 1);
    chk("t6_awaddr_wdata", {cap_awaddr, cap_wdata}, 64'h0000_0044_0102_0304);
    cfg_rdata = 32'hA1B2_C3D4;
    do_read(32'h0000_0048, 0);
    expect_tx("t6_read_reply", 40'h4BD4C3B2A1, 5);

    // T6: reset while waiting for the write response
    tx_toggle = 1'b0; w_dly = 0; b_stall = 1'b1;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    do_write(32'h0000_0050, 32'h7777_8888);
    begin
      int n;
      n = 0;
      while (!bready && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("t6_in_wresp", bready, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_valids", {rx_ready, tx_valid, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
    chk("t6_rst_regs", {awaddr, wdata}, 64'h0);
    chk("t6_rst_araddr_tx", {araddr, tx_data}, 40'h0);
    @(negedge clk);
    rst = 1'b0;
    b_stall = 1'b0;
    chk("t6_one_aw_w", {aw_hs - aw0, w_hs - w0}, {32'd1, 32'd1});
    chk("t6_no_b", b_hs - b0, 0);
    chk("t6_no_reply", tx_q.size(), 0);
    cfg_rdata = 32'h8765_4321;
    do_read(32'h0000_0060, 0);
    expect_tx("t6_recover", 40'h4B21436587, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
